// File: rtl/exe_branch_resolve.sv
// Branch resolution stage after the ALU: resolves branches against the front-end prediction,
// pulses a redirect on mispredict, and hands results to MEM/WB through a 2-entry skid FIFO.
package exe_branch_resolve_pkg;
  typedef enum logic [4:0] {
    ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLL_I, SRL_I, SRA_I, SLT_I, SLTU_I,
    LUI_I, AUIPC_I, JAL_I, JALR_I, LW_I, SW_I,
    BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I
  } instr_opcode;
endpackage

module exe_branch_resolve
  import exe_branch_resolve_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  instr_opcode      in_opcode,
  input  logic [XLEN-1:0]  in_aluout,
  input  logic             in_br_cond,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wb_en,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd;
    logic            wb_en;
  } entry_t;

  entry_t          head_q, tail_q, new_entry;
  logic [1:0]      count_q;
  logic            is_branch, taken, mispredict, push, pop, redirect_now;
  logic [XLEN-1:0] pc_plus4, actual_pc;

  always_comb begin
    is_branch  = in_opcode inside {BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I};
    taken      = in_br_cond;
    pc_plus4   = in_pc + XLEN'(4);
    actual_pc  = taken ? in_aluout : pc_plus4;
    mispredict = (taken != in_pred_taken) || (taken && (in_pred_target != in_aluout));
    new_entry.result = is_branch ? pc_plus4 : in_aluout;
    new_entry.rd     = in_rd;
    new_entry.wb_en  = !is_branch && (in_rd != '0);
  end

  // in_ready depends only on state, never on out_ready
  assign in_ready     = (count_q != 2'd2) && !redirect_valid;
  assign push         = in_valid && in_ready;
  assign out_valid    = (count_q != 2'd0);
  assign pop          = out_valid && out_ready;
  assign redirect_now = push && is_branch && mispredict;

  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_wb_en  = head_q.wb_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else begin
      redirect_valid <= redirect_now;
      if (redirect_now) redirect_pc <= actual_pc;

      if (push && is_branch) begin
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
        if (mispredict && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
      end

      // push+pop only occurs with one entry held: the new entry replaces the head
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= new_entry;
          else                 tail_q <= new_entry;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: head_q <= new_entry;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_branch_resolve.sv
// Self-checking bench for exe_branch_resolve: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_exe_branch_resolve;
  import exe_branch_resolve_pkg::*;

  localparam int XLEN  = 32;
  localparam int RD_W  = 5;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  instr_opcode      in_opcode;
  logic [XLEN-1:0]  in_aluout;
  logic             in_br_cond;
  logic [XLEN-1:0]  in_pc;
  logic [RD_W-1:0]  in_rd;
  logic             in_pred_taken;
  logic [XLEN-1:0]  in_pred_target;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wb_en;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  exe_branch_resolve #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_aluout(in_aluout), .in_br_cond(in_br_cond), .in_pc(in_pc), .in_rd(in_rd),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wb_en(out_wb_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [RD_W-1:0] rd;
    bit              wb;
  } exp_t;

  exp_t            q[$];
  bit              m_redir;
  logic [XLEN-1:0] m_rpc;
  int              m_br, m_mis;
  int              vectors, errors;

  function automatic bit model_is_branch(input instr_opcode op);
    return op == BEQ_I || op == BNE_I || op == BLT_I || op == BGE_I || op == BLTU_I || op == BGEU_I;
  endfunction

  task automatic model_reset();
    q.delete();
    m_redir = 0;
    m_rpc   = '0;
    m_br    = 0;
    m_mis   = 0;
  endtask

  // Called just after a falling edge: applies inputs, advances the model across the rising edge,
  // and returns at the next falling edge.
  task automatic drive(input bit v, input instr_opcode op, input logic [XLEN-1:0] alu,
                       input bit cond, input logic [XLEN-1:0] pc, input logic [RD_W-1:0] rd,
                       input bit pt, input logic [XLEN-1:0] ptgt, input bit ordy);
    bit acc, pop, br, mis;
    logic [XLEN-1:0] nxt, tgt;
    exp_t e;
    in_valid = v; in_opcode = op; in_aluout = alu; in_br_cond = cond; in_pc = pc;
    in_rd = rd; in_pred_taken = pt; in_pred_target = ptgt; out_ready = ordy;
    acc = v && (q.size() < 2) && !m_redir;
    pop = (q.size() != 0) && ordy;
    br  = model_is_branch(op);
    nxt = pc + 4;
    tgt = cond ? alu : nxt;
    mis = br && ((cond != pt) || (cond && ptgt != alu));
    e.res = br ? nxt : alu;
    e.rd  = rd;
    e.wb  = !br && (rd != 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
    m_redir = acc && mis;
    if (m_redir) m_rpc = tgt;
    if (acc && br) begin
      if (m_br < MAXC) m_br++;
      if (mis && m_mis < MAXC) m_mis++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    drive(0, ADD_I, '0, 0, '0, '0, 0, '0, ordy);
  endtask

  task automatic test_reset();
    rst = 1; out_ready = 0;
    idle(0);
    idle(0);
    model_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (redirect_valid !== 1'b0 || redirect_pc !== '0) begin errors++;
      $display("FAIL reset_redirect got %b/%h want 0/0", redirect_valid, redirect_pc); end
    vectors++; if (br_count !== '0 || mispred_count !== '0) begin errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", br_count, mispred_count); end
    rst = 0;
    idle(1);
  endtask

  task automatic test_add();
    drive(1, ADD_I, 32'd5, 0, 32'h80, 5'd3, 0, '0, 1);
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_rd !== 5'd3 || out_wb_en !== 1'b1) begin errors++;
      $display("FAIL add_result got v=%b r=%h rd=%0d wb=%b want 1/5/3/1", out_valid, out_result, out_rd, out_wb_en); end
    vectors++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL add_no_redirect got %b want 0", redirect_valid); end
    idle(1);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b want 0", out_valid); end
  endtask

  task automatic test_mispredict();
    drive(1, BEQ_I, 32'h140, 1, 32'h100, 5'd7, 0, 32'h0, 1);
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h140) begin errors++;
      $display("FAIL beq_redirect got %b/%h want 1/140", redirect_valid, redirect_pc); end
    vectors++; if (mispred_count !== 8'd1 || br_count !== 8'd1) begin errors++;
      $display("FAIL beq_counters got %0d/%0d want 1/1", br_count, mispred_count); end
    vectors++; if (out_valid !== 1'b1 || out_wb_en !== 1'b0 || out_result !== 32'h104) begin errors++;
      $display("FAIL beq_entry got v=%b wb=%b r=%h want 1/0/104", out_valid, out_wb_en, out_result); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL beq_in_ready got %b want 0", in_ready); end
    drive(1, ADD_I, 32'hdead, 0, 32'h104, 5'd9, 0, '0, 1);
    vectors++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL beq_wrong_path_dropped got redir=%b v=%b want 0/0", redirect_valid, out_valid); end
  endtask

  task automatic test_bne();
    int br0;
    drive(1, BNE_I, 32'h300, 0, 32'h200, 5'd0, 1, 32'h300, 1);
    vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204) begin errors++;
      $display("FAIL bne_redirect got %b/%h want 1/204", redirect_valid, redirect_pc); end
    idle(1);
    br0 = int'(br_count);
    drive(1, BNE_I, 32'h300, 0, 32'h200, 5'd0, 0, 32'h300, 1);
    vectors++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bne_correct_no_redirect got %b want 0", redirect_valid); end
    vectors++; if (int'(br_count) !== br0 + 1) begin errors++;
      $display("FAIL bne_br_count got %0d want %0d", br_count, br0 + 1); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    bit exp_rdy;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      exp_rdy = (i < 2);
      vectors++; if (in_ready !== exp_rdy) begin errors++;
        $display("FAIL b2b_in_ready[%0d] got %b want %b", i, in_ready, exp_rdy); end
      drive(1, ADD_I, 32'h1000 + i, 0, '0, 5'(i + 1), 0, '0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_result !== 32'h1000 + i || out_rd !== 5'(i + 1)) begin errors++;
        $display("FAIL b2b_drain[%0d] got v=%b r=%h rd=%0d want 1/%h/%0d", i, out_valid, out_result, out_rd, 32'h1000 + i, i + 1); end
      idle(1);
    end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    bit v, c, pt, ordy;
    instr_opcode op;
    logic [XLEN-1:0] alu, pc, ptgt;
    for (int n = 0; n < 3000; n++) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      op   = instr_opcode'($urandom_range(0, 21));
      alu  = $urandom;
      pc   = $urandom;
      c    = $urandom_range(0, 1);
      pt   = $urandom_range(0, 1);
      ptgt = $urandom_range(0, 1) ? alu : 32'($urandom);
      drive(v, op, alu, c, pc, 5'($urandom_range(0, 3)), pt, ptgt, ordy);
      vectors++; if (out_valid !== (q.size() != 0)) begin errors++;
        $display("FAIL rnd_out_valid@%0d got %b want %b", n, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        vectors++; if (out_result !== q[0].res || out_rd !== q[0].rd || out_wb_en !== q[0].wb) begin errors++;
          $display("FAIL rnd_head@%0d got %h/%0d/%b want %h/%0d/%b", n, out_result, out_rd, out_wb_en, q[0].res, q[0].rd, q[0].wb); end
      end
      vectors++; if (in_ready !== ((q.size() < 2) && !m_redir)) begin errors++;
        $display("FAIL rnd_in_ready@%0d got %b want %b", n, in_ready, (q.size() < 2) && !m_redir); end
      vectors++; if (redirect_valid !== m_redir || (m_redir && redirect_pc !== m_rpc)) begin errors++;
        $display("FAIL rnd_redirect@%0d got %b/%h want %b/%h", n, redirect_valid, redirect_pc, m_redir, m_rpc); end
      vectors++; if (int'(br_count) !== m_br || int'(mispred_count) !== m_mis) begin errors++;
        $display("FAIL rnd_counters@%0d got %0d/%0d want %0d/%0d", n, br_count, mispred_count, m_br, m_mis); end
    end
    idle(1); idle(1);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 2 * MAXC && m_mis < MAXC; n++) begin
      drive(1, BLT_I, 32'h40, 1, 32'h10, '0, 0, '0, 1);
      idle(1);
    end
    vectors++; if (int'(mispred_count) !== MAXC) begin errors++;
      $display("FAIL sat_reached got %0d want %0d", mispred_count, MAXC); end
    drive(1, BGEU_I, 32'h40, 1, 32'h10, '0, 0, '0, 1);
    vectors++; if (int'(mispred_count) !== MAXC || int'(br_count) !== MAXC) begin errors++;
      $display("FAIL sat_hold got %0d/%0d want %0d/%0d", br_count, mispred_count, MAXC, MAXC); end
    idle(1);
  endtask

  task automatic test_reset_midop();
    drive(1, SUB_I, 32'h55, 0, '0, 5'd4, 0, '0, 0);
    drive(1, BGE_I, 32'h900, 1, 32'h800, '0, 0, '0, 0);
    vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || redirect_valid !== 1'b1) begin errors++;
      $display("FAIL midrst_setup got v=%b rdy=%b redir=%b want 1/0/1", out_valid, in_ready, redirect_valid); end
    in_valid = 0;
    rst = 1;
    #1;
    model_reset();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== '0) begin errors++;
      $display("FAIL midrst_async got v=%b rdy=%b redir=%b pc=%h want 0/1/0/0", out_valid, in_ready, redirect_valid, redirect_pc); end
    vectors++; if (br_count !== '0 || mispred_count !== '0) begin errors++;
      $display("FAIL midrst_counters got %0d/%0d want 0/0", br_count, mispred_count); end
    @(negedge clk);
    rst = 0;
    idle(1);
    vectors++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_after got v=%b redir=%b want 0/0", out_valid, redirect_valid); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    model_reset();
    rst = 1;
    in_valid = 0; in_opcode = ADD_I; in_aluout = '0; in_br_cond = 0; in_pc = '0;
    in_rd = '0; in_pred_taken = 0; in_pred_target = '0; out_ready = 0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mispredict();
    test_bne();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
